// File: rtl/cache_pkg.sv
// Shared types and constants for the main-memory-side cache controller.
// Block geometry is fixed at 16-byte blocks of four 32-bit words.
package cache_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int WPB         = 4;
  localparam int LA_W        = 4;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FILL,
    FWAIT
  } ctrl_state_t;

  // The address field holds a zero-extended RAM word address.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cache_wbuf.sv
// Posted write buffer: synchronous FIFO of wb_entry_t with a
// combinational head view so the controller can write it out in the same cycle.
module cache_wbuf
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  wb_entry_t                    din,
  output wb_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Main-memory controller behind the cache: posts write-through stores in a
// small buffer and serialises block fills behind them to keep memory order.
module cache_mem_ctrl
  import cache_pkg::*;
#(
  parameter int MEM_AW   = 16,
  parameter int WB_DEPTH = 4,
  parameter int MEM_LAT  = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [1:0]        resp_word,
  output logic              resp_last,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        wb_count
);

  localparam int CW = $clog2(WB_DEPTH + 1);

  ctrl_state_t        state;
  ctrl_state_t        state_nx;
  logic [1:0]         fill_k;
  logic [MEM_AW-3:0]  base;
  logic [MEM_LAT-1:0] pipe_v;
  logic [1:0]         pipe_w [MEM_LAT];

  logic               wb_full;
  logic               wb_empty;
  logic [CW-1:0]      wb_cnt;
  wb_entry_t          wb_din;
  wb_entry_t          wb_head;

  logic               acc;
  logic               wr_acc;
  logic               rd_acc;
  logic               pop;
  logic               issue;
  logic               unused_bits;

  // Ready is held low while CLR is asserted so every output reads 0 in reset.
  assign req_ready = CLR && (state == IDLE) && (!req_we || !wb_full);
  assign acc       = req_valid && req_ready;
  assign wr_acc    = acc && req_we;
  assign rd_acc    = acc && !req_we;
  assign pop       = !wb_empty && (state != FILL);
  assign issue     = (state == FILL);

  assign wb_din.addr = ADDR_W'(req_addr[MEM_AW+1:2]);
  assign wb_din.data = req_wdata;
  assign wb_count    = 3'(wb_cnt);

  cache_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clk   (CLK),
    .rst_n (CLR),
    .push  (wr_acc),
    .pop   (pop),
    .din   (wb_din),
    .head  (wb_head),
    .full  (wb_full),
    .empty (wb_empty),
    .count (wb_cnt)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE:    if (rd_acc) state_nx = wb_empty ? FILL : DRAIN;
      DRAIN:   if (wb_empty) state_nx = FILL;
      FILL:    if (fill_k == 2'(WPB - 1)) state_nx = FWAIT;
      FWAIT:   if (resp_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (issue) begin
      mem_en   = 1'b1;
      mem_addr = {base, fill_k};
    end else if (pop) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wb_head.addr[MEM_AW-1:0];
      mem_wdata = wb_head.data;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state  <= IDLE;
      fill_k <= '0;
      base   <= '0;
      pipe_v <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_w[i] <= '0;
    end else begin
      state <= state_nx;
      if (rd_acc) base <= req_addr[MEM_AW+1:LA_W];
      if (issue)  fill_k <= fill_k + 1'b1;
      pipe_v[0] <= issue;
      pipe_w[0] <= fill_k;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_w[i] <= pipe_w[i-1];
      end
    end
  end

  // The latency pipe lines each read's word tag up with its returning RAM data.
  assign resp_valid = pipe_v[MEM_LAT-1];
  assign resp_word  = resp_valid ? pipe_w[MEM_LAT-1] : 2'b00;
  assign resp_last  = resp_valid && (pipe_w[MEM_LAT-1] == 2'(WPB - 1));
  assign resp_data  = resp_valid ? mem_rdata : '0;

  assign unused_bits = ^{req_addr[ADDR_W-1:MEM_AW+2], req_addr[1:0],
                         wb_head.addr[ADDR_W-1:MEM_AW]};

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl: a RAM model, a transaction-level
// reference (pending-write queue, expected fill words) and directed literal checks.
module tb_cache_mem_ctrl;

  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_word;
  logic        resp_last;
  logic        mem_en;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  wb_count;

  always #5 CLK = ~CLK;

  cache_mem_ctrl #(.MEM_AW(AW), .WB_DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .CLR(CLR),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_word(resp_word),
    .resp_last(resp_last),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wb_count(wb_count)
  );

  // RAM model: word-addressed, reads return LAT cycles after the strobe.
  logic [31:0] ram    [1<<AW];
  logic [31:0] shadow [1<<AW];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge CLK) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(act === exp, name, act, exp);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    int          word;
    bit          last;
    int          at;
  } rsp_t;

  wr_t           exp_wr  [$];
  logic [AW-1:0] exp_iss [$];
  rsp_t          exp_rsp [$];
  bit            busy = 1'b0;
  int            busy_cyc = 0;

  // A fill sees shadow RAM with every still-pending earlier write applied.
  function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
    logic [31:0] v;
    v = shadow[a];
    foreach (exp_wr[i]) if (exp_wr[i].addr == a) v = exp_wr[i].data;
    return v;
  endfunction

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge CLK) begin : model
    int          cnt;
    wr_t         w;
    rsp_t        r;
    logic [AW-1:0] a;
    logic [AW-1:0] base;
    cnt = exp_wr.size();
    if (!CLR) begin
      check_eq("rst_ctrl", {22'd0, req_ready, resp_valid, resp_last, mem_en, mem_we,
                            resp_word, wb_count}, 32'd0);
      check_eq("rst_data", resp_data | mem_wdata | 32'(mem_addr), 32'd0);
      exp_wr.delete();
      exp_iss.delete();
      exp_rsp.delete();
      busy = 1'b0;
    end else begin
      check_eq("wb_count", 32'(wb_count), 32'(cnt));
      check_eq("req_ready", 32'(req_ready), 32'(!busy && (!req_we || cnt < DEPTH)));
      check_eq("drain_active", 32'(mem_en && mem_we), 32'(cnt > 0));
      if (!mem_we) check_eq("wdata_zero", mem_wdata, 32'd0);
      if (mem_en && mem_we && cnt > 0) begin
        w = exp_wr.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(w.addr));
        check_eq("wr_data", mem_wdata, w.data);
        shadow[w.addr] = w.data;
      end
      if (mem_en && !mem_we) begin
        check(cnt == 0, "fill_before_write", 32'(cnt), 32'd0);
        if (exp_iss.size() == 0) check(1'b0, "unexpected_issue", 32'(mem_addr), 32'd0);
        else begin
          a = exp_iss.pop_front();
          check_eq("issue_addr", 32'(mem_addr), 32'(a));
        end
      end
      if (resp_valid) begin
        if (exp_rsp.size() == 0) check(1'b0, "unexpected_resp", resp_data, 32'd0);
        else begin
          r = exp_rsp.pop_front();
          check_eq("resp_data", resp_data, r.data);
          check_eq("resp_word", 32'(resp_word), 32'(r.word));
          check_eq("resp_last", 32'(resp_last), 32'(r.last));
          if (r.at >= 0) check_eq("resp_cycle", 32'(cyc), 32'(r.at));
          if (r.last) busy = 1'b0;
        end
      end
      if (busy) begin
        busy_cyc++;
        if (busy_cyc > 100) begin
          check(1'b0, "fill_timeout", 32'(exp_rsp.size()), 32'd0);
          busy = 1'b0;
          exp_iss.delete();
          exp_rsp.delete();
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          w.addr = req_addr[AW+1:2];
          w.data = req_wdata;
          exp_wr.push_back(w);
        end else begin
          busy     = 1'b1;
          busy_cyc = 0;
          base     = {req_addr[AW+1:4], 2'b00};
          for (int k = 0; k < 4; k++) begin
            a      = base + AW'(k);
            r.data = exp_word(a);
            r.word = k;
            r.last = (k == 3);
            r.at   = (cnt == 0) ? cyc + 1 + LAT + k : -1;
            exp_iss.push_back(a);
            exp_rsp.push_back(r);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Entered at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input bit we, input logic [31:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (req_ready) break;
    end
    if (n == 100) check(1'b0, "send_timeout", a, d);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (!busy && exp_wr.size() == 0 && exp_rsp.size() == 0) break;
    end
    if (n == 300) check(1'b0, "idle_timeout", 32'(exp_rsp.size()), 32'd0);
    step();
  endtask

  // Literal pinning of the empty-buffer fill timeline after the accept edge.
  task automatic fill_literals(input logic [AW-1:0] base, input logic [31:0] first);
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      check_eq("lit_ready_low", 32'(req_ready), 32'd0);
      if (i <= 4) begin
        check_eq("lit_issue_en", 32'({mem_en, mem_we}), 32'd2);
        check_eq("lit_issue_addr", 32'(mem_addr), 32'(base) + 32'(i - 1));
      end
      if (i >= 3) begin
        check_eq("lit_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("lit_resp_data", resp_data, first + 32'(i - 3) * 32'h1111_1111);
        check_eq("lit_resp_word", 32'(resp_word), 32'(i - 3));
        check_eq("lit_resp_last", 32'(resp_last), 32'(i == 6));
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = 32'(i) * 32'h1111_1111;
      shadow[i] = 32'(i) * 32'h1111_1111;
    end
    repeat (3) @(posedge CLK);
    #1 CLR = 1'b1;
    @(negedge CLK);
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);
    check_eq("post_rst_wbc", 32'(wb_count), 32'd0);
    step();

    send(1'b0, 32'h0000_0000, 32'd0);
    fill_literals(16'd0, 32'h0000_0000);
    wait_idle();

    send(1'b0, 32'h0000_0014, 32'd0);
    fill_literals(16'd4, 32'h4444_4444);
    wait_idle();

    send(1'b1, 32'h0000_0028, 32'h8888_8888);
    @(negedge CLK);
    check_eq("lit_wb_one", 32'(wb_count), 32'd1);
    check_eq("lit_wr_we", 32'({mem_en, mem_we}), 32'd3);
    check_eq("lit_wr_addr", 32'(mem_addr), 32'd10);
    check_eq("lit_wr_data", mem_wdata, 32'h8888_8888);
    @(negedge CLK);
    check_eq("lit_wb_zero", 32'(wb_count), 32'd0);
    wait_idle();

    send(1'b1, 32'h0000_003C, 32'h3333_3333);
    send(1'b0, 32'h0000_0030, 32'd0);
    for (n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (resp_valid && resp_last) break;
    end
    check(n < 50, "drain_fill_timeout", 32'(n), 32'd50);
    check_eq("lit_drain_word3", resp_data, 32'h3333_3333);
    check_eq("lit_drain_idx", 32'(resp_word), 32'd3);
    wait_idle();

    send(1'b0, 32'h0000_0040, 32'd0);
    for (int i = 0; i < 5; i++) send(1'b1, 32'h0000_0040 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    wait_idle();
    for (int i = 0; i < 5; i++) check_eq("lit_burst_ram", ram[16 + i], 32'hA000_0000 + 32'(i));

    send(1'b0, 32'h0000_0100, 32'd0);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 CLR = 1'b0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 CLR = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_eq("abort_no_resp", 32'({resp_valid, resp_last}), 32'd0);
    end
    step();

    for (int it = 0; it < 1500; it++) begin
      repeat ($urandom_range(0, 2)) step();
      send($urandom_range(0, 3) != 0, $urandom & 32'hFFFC_00FF, $urandom);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
